// File: rtl/root_calc_arbiter.sv
// root_calc_arbiter: round-robin front end that shares one RES = (A - 3*B) - TEMP
// datapath among NREQ requesters. At most one operation is in flight at a time.
// Build option ROOT_ARB_SAT_EN: wide signed arithmetic, with negative results
// clamped to zero. When it is undefined, every step wraps modulo 2^DW.
module root_calc_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DW       = 8,
   parameter int unsigned TEMP_RST = 21,
   localparam int unsigned IW      = $clog2(NREQ)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    REQ_VALID,
   input  logic [NREQ*DW-1:0] REQ_A,
   input  logic [NREQ*DW-1:0] REQ_B,
   output logic [NREQ-1:0]    REQ_READY,
   output logic               RES_VALID,
   input  logic               RES_READY,
   output logic [DW-1:0]      RES_DATA,
   output logic [IW-1:0]      RES_ID,
   input  logic               CFG_WE,
   input  logic [DW-1:0]      CFG_TEMP,
   output logic               BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [DW-1:0]   temp_q, temp_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   tsnap_q, tsnap_d;
   logic [IW-1:0]   id_q, id_d;
   logic [DW-1:0]   res_data_q, res_data_d;
   logic [IW-1:0]   res_id_q, res_id_d;
   logic            res_valid_q, res_valid_d;
   logic            busy_q, busy_d;

   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   scan_idx;
   logic [DW-1:0]   calc_res;

   // Pick the first valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = IW'((32'(rr_q) + k) % NREQ);
         if (!grant_found && REQ_VALID[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

`ifdef ROOT_ARB_SAT_EN
   localparam int unsigned XW = DW + 3;
   logic [XW-1:0] wide;

   // Signed wide result; the sign bit selects the clamp to zero.
   always_comb begin
      wide     = XW'(a_q) - (XW'(b_q) << 1) - XW'(b_q) - XW'(tsnap_q);
      calc_res = wide[XW-1] ? '0 : wide[DW-1:0];
   end
`else
   logic [DW-1:0] b3;

   // Modulo 2^DW at every step: 3*B wraps before the subtractions.
   always_comb begin
      b3       = (b_q << 1) + b_q;
      calc_res = a_q - b3 - tsnap_q;
   end
`endif

   // Grant strobe is combinational and only offered in IDLE.
   always_comb begin
      REQ_READY = '0;
      if (!RST && state_q == IDLE && grant_found) begin
         REQ_READY[grant_idx] = 1'b1;
      end
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      temp_d      = temp_q;
      a_d         = a_q;
      b_d         = b_q;
      tsnap_d     = tsnap_q;
      id_d        = id_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      res_valid_d = res_valid_q;

      if (CFG_WE) begin
         temp_d = CFG_TEMP;
      end

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               a_d     = REQ_A[32'(grant_idx) * DW +: DW];
               b_d     = REQ_B[32'(grant_idx) * DW +: DW];
               tsnap_d = temp_q;
               id_d    = grant_idx;
               state_d = CALC;
            end
         end
         CALC: begin
            res_data_d  = calc_res;
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (RES_READY) begin
               res_valid_d = 1'b0;
               rr_d        = IW'((32'(id_q) + 32'd1) % NREQ);
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         temp_q      <= DW'(TEMP_RST);
         a_q         <= '0;
         b_q         <= '0;
         tsnap_q     <= '0;
         id_q        <= '0;
         res_data_q  <= '0;
         res_id_q    <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         temp_q      <= temp_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tsnap_q     <= tsnap_d;
         id_q        <= id_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign RES_VALID = res_valid_q;
   assign RES_DATA  = res_data_q;
   assign RES_ID    = res_id_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_root_calc_arbiter.sv
// Testbench for root_calc_arbiter: a table of single-op vectors, hand sequences for
// round-robin order, output stall and mid-op reset, and a negedge scoreboard.
module tb_root_calc_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 8;

   logic             CLK;
   logic             RST;
   logic [NREQ-1:0]  REQ_VALID;
   logic [NREQ*DW-1:0] REQ_A;
   logic [NREQ*DW-1:0] REQ_B;
   logic [NREQ-1:0]  REQ_READY;
   logic             RES_VALID;
   logic             RES_READY;
   logic [DW-1:0]    RES_DATA;
   logic [1:0]       RES_ID;
   logic             CFG_WE;
   logic [DW-1:0]    CFG_TEMP;
   logic             BUSY;

   root_calc_arbiter #(.NREQ(NREQ), .DW(DW), .TEMP_RST(21)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_READY(REQ_READY),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ID(RES_ID),
      .CFG_WE(CFG_WE), .CFG_TEMP(CFG_TEMP), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Reference arithmetic.
   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] t);
`ifdef ROOT_ARB_SAT_EN
      int r;
      r = int'(a) - 3 * int'(b) - int'(t);
      return (r < 0) ? 8'd0 : 8'(r);
`else
      logic [7:0] b3;
      b3 = 8'(3 * int'(b));
      return a - b3 - t;
`endif
   endfunction

   // Scoreboard: expectations pushed at accept, popped at the result handshake.
   typedef struct {
      logic [7:0] data;
      logic [1:0] id;
   } exp_t;
   exp_t sb[$];
   int   m_rr   = 0;
   logic [7:0] m_temp = 8'd21;

   always @(negedge CLK) begin
      int   g;
      exp_t e;
      if (RST) begin
         sb.delete();
         m_rr   = 0;
         m_temp = 8'd21;
      end else begin
         if (|(REQ_VALID & REQ_READY)) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && REQ_VALID[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            end
            chk("sb_grant", 32'(REQ_READY), 32'(4'b0001 << g));
            e.data = model(REQ_A[g*8 +: 8], REQ_B[g*8 +: 8], m_temp);
            e.id   = 2'(g);
            sb.push_back(e);
         end
         if (RES_VALID && RES_READY) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: got result %0d id %0d required none", RES_DATA, RES_ID);
            end else begin
               e = sb.pop_front();
               chk("sb_data", 32'(RES_DATA), 32'(e.data));
               chk("sb_id", 32'(RES_ID), 32'(e.id));
               m_rr = (int'(e.id) + 1) % 4;
            end
         end
         if (CFG_WE) m_temp = CFG_TEMP;
      end
   end

   typedef struct {
      logic [3:0] valid;
      logic [7:0] a;
      logic [7:0] b;
      logic       cfg_we;
      logic [7:0] cfg_temp;
      logic [3:0] exp_ready;
      logic [7:0] exp_data;
      logic [1:0] exp_id;
   } vec_t;
   vec_t vecs[8];

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1);
   end

   initial begin
      // Single-op vectors in sequence; the rr pointer carries over between them.
      vecs[0] = '{4'b0001, 8'd100, 8'd10,  1'b0, 8'd0, 4'b0001, 8'd49,  2'd0};
`ifdef ROOT_ARB_SAT_EN
      vecs[1] = '{4'b0001, 8'd0,   8'd1,   1'b0, 8'd0, 4'b0001, 8'd0,   2'd0};
      vecs[2] = '{4'b1111, 8'd20,  8'd2,   1'b0, 8'd0, 4'b0010, 8'd0,   2'd1};
      vecs[4] = '{4'b1000, 8'd255, 8'd255, 1'b0, 8'd0, 4'b1000, 8'd0,   2'd3};
`else
      vecs[1] = '{4'b0001, 8'd0,   8'd1,   1'b0, 8'd0, 4'b0001, 8'd232, 2'd0};
      vecs[2] = '{4'b1111, 8'd20,  8'd2,   1'b0, 8'd0, 4'b0010, 8'd249, 2'd1};
      vecs[4] = '{4'b1000, 8'd255, 8'd255, 1'b0, 8'd0, 4'b1000, 8'd237, 2'd3};
`endif
      vecs[3] = '{4'b0011, 8'd200, 8'd5,   1'b0, 8'd0, 4'b0001, 8'd164, 2'd0};
      vecs[5] = '{4'b1100, 8'd50,  8'd0,   1'b1, 8'd0, 4'b0100, 8'd29,  2'd2};
      vecs[6] = '{4'b0110, 8'd9,   8'd3,   1'b0, 8'd0, 4'b0010, 8'd0,   2'd1};
      vecs[7] = '{4'b0101, 8'd10,  8'd0,   1'b0, 8'd0, 4'b0100, 8'd10,  2'd2};

      RST = 1'b1; REQ_VALID = '0; REQ_A = '0; REQ_B = '0;
      RES_READY = 1'b1; CFG_WE = 1'b0; CFG_TEMP = '0;
      cyc(); cyc();
      RST = 1'b0;
      #1;
      chk("rst_res_valid", 32'(RES_VALID), 32'd0);
      chk("rst_res_data", 32'(RES_DATA), 32'd0);
      chk("rst_res_id", 32'(RES_ID), 32'd0);
      chk("rst_req_ready", 32'(REQ_READY), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);

      // Table: accept, CALC, OUT with immediate handshake, back to IDLE.
      for (int i = 0; i < 8; i++) begin
         cyc();
         REQ_VALID = vecs[i].valid;
         REQ_A     = {4{vecs[i].a}};
         REQ_B     = {4{vecs[i].b}};
         CFG_WE    = vecs[i].cfg_we;
         CFG_TEMP  = vecs[i].cfg_temp;
         #1;
         chk("vec_grant", 32'(REQ_READY), 32'(vecs[i].exp_ready));
         cyc();
         REQ_VALID = '0;
         CFG_WE    = 1'b0;
         #1;
         chk("vec_calc_ready", 32'(REQ_READY), 32'd0);
         chk("vec_calc_busy", 32'(BUSY), 32'd1);
         chk("vec_calc_valid", 32'(RES_VALID), 32'd0);
         cyc();
         #1;
         chk("vec_out_valid", 32'(RES_VALID), 32'd1);
         chk("vec_out_data", 32'(RES_DATA), 32'(vecs[i].exp_data));
         chk("vec_out_id", 32'(RES_ID), 32'(vecs[i].exp_id));
         cyc();
         #1;
         chk("vec_idle_valid", 32'(RES_VALID), 32'd0);
         chk("vec_idle_busy", 32'(BUSY), 32'd0);
      end

      // All four requesting continuously: grants 0,1,2,3,0 one every 3 cycles.
      cyc();
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      REQ_VALID = 4'b1111;
      REQ_A = {8'd40, 8'd30, 8'd20, 8'd10};
      REQ_B = '0;
      #1;
      for (int c = 0; c < 15; c++) begin
         chk("rr_grant", 32'(REQ_READY), (c % 3 == 0) ? (32'd1 << ((c / 3) % 4)) : 32'd0);
         cyc();
         #1;
      end
      REQ_VALID = '0;
      cyc(); cyc();

      // Output stall: result held for 5 cycles with no grants offered.
      REQ_VALID = 4'b0100;
      REQ_A = {4{8'd77}};
      REQ_B = {4{8'd4}};
      RES_READY = 1'b0;
      #1;
      chk("stall_grant", 32'(REQ_READY), 32'b0100);
      cyc();
      REQ_VALID = 4'b1111;
      cyc();
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("stall_valid", 32'(RES_VALID), 32'd1);
         chk("stall_data", 32'(RES_DATA), 32'd44);
         chk("stall_id", 32'(RES_ID), 32'd2);
         chk("stall_ready", 32'(REQ_READY), 32'd0);
         chk("stall_busy", 32'(BUSY), 32'd1);
         cyc();
      end
      RES_READY = 1'b1;
      REQ_VALID = '0;
      cyc();
      #1;
      chk("stall_rel_valid", 32'(RES_VALID), 32'd0);
      chk("stall_rel_busy", 32'(BUSY), 32'd0);

      // Reset during CALC drops the op and restores TEMP and the pointer.
      CFG_WE = 1'b1;
      CFG_TEMP = 8'd5;
      cyc();
      CFG_WE = 1'b0;
      REQ_VALID = 4'b0010;
      REQ_A = {4{8'd60}};
      REQ_B = {4{8'd1}};
      #1;
      chk("mrst_grant", 32'(REQ_READY), 32'b0010);
      cyc();
      REQ_VALID = '0;
      RST = 1'b1;
      #1;
      chk("mrst_calc_busy", 32'(BUSY), 32'd1);
      cyc();
      RST = 1'b0;
      #1;
      chk("mrst_valid", 32'(RES_VALID), 32'd0);
      chk("mrst_busy", 32'(BUSY), 32'd0);
      chk("mrst_data", 32'(RES_DATA), 32'd0);
      REQ_VALID = 4'b1111;
      REQ_A = {4{8'd100}};
      REQ_B = {4{8'd10}};
      #1;
      chk("mrst_rr_grant", 32'(REQ_READY), 32'b0001);
      cyc();
      REQ_VALID = '0;
      #1;
      chk("mrst_calc_valid", 32'(RES_VALID), 32'd0);
      cyc();
      #1;
      chk("mrst_out_valid", 32'(RES_VALID), 32'd1);
      chk("mrst_out_data", 32'(RES_DATA), 32'd49);
      chk("mrst_out_id", 32'(RES_ID), 32'd0);
      cyc(); cyc();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
